slab_hit_reducer: RTL

- Consumes per-axis slab intervals (t_near, t_far) for one ray against one AABB, one axis per beat. Upstream has already ordered each pair so that t_near <= t_far.
- Runs the slab-test reduction:
  - t_enter = max over axes of t_near.
  - t_exit = min over axes of t_far.
  - hit when t_enter <= t_exit and t_exit >= 0.
- Sits directly downstream of the per-axis slab compare stage in the Ray-AABB pipeline.
- All values use the FloPoCo wE=11 / wF=1 word format:
  - [width:width-1] = exception code: 00 zero, 01 normal, 10 inf, 11 NaN.
  - [width-2] = sign.
  - [width-3:0] = exponent || fraction.

---
 rtl/slab_hit_reducer_pkg.sv | 26 ++
 rtl/slab_hit_reducer_if.sv | 43 ++++
 rtl/slab_hit_reducer_fp_order_lt.sv | 62 ++++++
 rtl/slab_hit_reducer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/slab_hit_reducer_pkg.sv
// slab_hit_reducer shared types and field layout.
// FloPoCo word: {exc[1:0], sign, exponent||fraction}.
package slab_hit_reducer_pkg;

  localparam int DEF_WIDTH = 14;
  localparam int DEF_AXES  = 3;

  // Field positions as offsets below the word MSB
  localparam int EXC_LO_OFS = 1;
  localparam int SGN_OFS    = 2;
  localparam int MAG_OFS    = 3;

  typedef enum logic [1:0] {
    EXC_ZERO = 2'b00,
    EXC_NORM = 2'b01,
    EXC_INF  = 2'b10,
    EXC_NAN  = 2'b11
  } exc_e;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DECIDE = 2'd1,
    OUT    = 2'd2
  } state_e;

endpackage

// File: rtl/slab_hit_reducer_if.sv
// Axis-beat input and result output handshakes
// for the slab hit reducer.
interface slab_hit_reducer_if
  import slab_hit_reducer_pkg::*;
#(
  parameter int width = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [width:0]   t_near;
  logic [width:0]   t_far;
  logic             out_valid;
  logic             out_ready;
  logic             hit;
  logic [width:0]   t_enter;
  logic [width:0]   t_exit;

  modport master (
    output in_valid,
    output t_near,
    output t_far,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  hit,
    input  t_enter,
    input  t_exit
  );

  modport slave (
    input  in_valid,
    input  t_near,
    input  t_far,
    input  out_ready,
    output in_ready,
    output out_valid,
    output hit,
    output t_enter,
    output t_exit
  );

endinterface

// File: rtl/slab_hit_reducer_fp_order_lt.sv
// Strict less-than on FloPoCo words; NaN on
// either side compares false, signed zeros tie.
module fp_order_lt
  import slab_hit_reducer_pkg::*;
#(
  parameter int width = DEF_WIDTH
) (
  input  logic [width:0] a,
  input  logic [width:0] b,
  output logic           lt
);

  localparam int MH = width - MAG_OFS;

  exc_e          ea;
  exc_e          eb;
  logic          sa;
  logic          sb;
  logic [MH:0]   ma;
  logic [MH:0]   mb;
  logic [2:0]    ra;
  logic [2:0]    rb;
  logic          any_nan;

  // Class rank: -inf < -norm < zero < +norm < +inf
  function automatic logic [2:0] rank(
    input exc_e e,
    input logic s
  );
    logic [2:0] r;
    r = 3'd2;
    case (e)
      EXC_NORM: r = s ? 3'd1 : 3'd3;
      EXC_INF:  r = s ? 3'd0 : 3'd4;
      default:  r = 3'd2;
    endcase
    return r;
  endfunction

  assign ea = exc_e'(a[width -: 2]);
  assign eb = exc_e'(b[width -: 2]);
  assign sa = a[width - SGN_OFS];
  assign sb = b[width - SGN_OFS];
  assign ma = a[MH:0];
  assign mb = b[MH:0];
  assign ra = rank(ea, sa);
  assign rb = rank(eb, sb);
  assign any_nan = (ea == EXC_NAN)
                 | (eb == EXC_NAN);

  always_comb begin
    lt = 1'b0;
    priority case (1'b1)
      any_nan:         lt = 1'b0;
      (ra != rb):      lt = (ra < rb);
      (ea == EXC_NORM): lt = sa ? (ma > mb)
                                : (ma < mb);
      default:         lt = 1'b0;
    endcase
  end

endmodule

// File: rtl/slab_hit_reducer.sv
// Reduces per-axis slab intervals to t_enter/t_exit
// and a hit flag for one ray against one AABB.
module slab_hit_reducer
  import slab_hit_reducer_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int AXES  = DEF_AXES
) (
  input  logic               clk,
  input  logic               rst,
  slab_hit_reducer_if.slave  bus
);

  localparam int CW = (AXES > 1) ? $clog2(AXES) : 1;
  localparam logic [CW-1:0] LAST = CW'(AXES - 1);
  localparam logic [width:0] ZERO_W = '0;

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            nan_q;
  logic            nan_d;
  logic            hit_q;
  logic            hit_d;
  logic [width:0]  enter_q;
  logic [width:0]  enter_d;
  logic [width:0]  exit_q;
  logic [width:0]  exit_d;

  logic            near_gt;
  logic            far_lt;
  logic            exit_lt_enter;
  logic            exit_neg;
  logic            nan_in;
  logic            accept;

  fp_order_lt #(.width(width)) u_lt_enter (
    .a  (enter_q),
    .b  (bus.t_near),
    .lt (near_gt)
  );

  fp_order_lt #(.width(width)) u_lt_exit (
    .a  (bus.t_far),
    .b  (exit_q),
    .lt (far_lt)
  );

  fp_order_lt #(.width(width)) u_lt_cross (
    .a  (exit_q),
    .b  (enter_q),
    .lt (exit_lt_enter)
  );

  fp_order_lt #(.width(width)) u_lt_zero (
    .a  (exit_q),
    .b  (ZERO_W),
    .lt (exit_neg)
  );

  assign nan_in = (bus.t_near[width -: 2] == EXC_NAN)
                | (bus.t_far[width -: 2]  == EXC_NAN);
  assign accept = bus.in_valid
                & (state_q == ACCUM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nan_d   = nan_q;
    hit_d   = hit_q;
    enter_d = enter_q;
    exit_d  = exit_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cnt_q == '0) begin
            enter_d = bus.t_near;
            exit_d  = bus.t_far;
            nan_d   = nan_in;
          end else begin
            if (near_gt) enter_d = bus.t_near;
            if (far_lt)  exit_d  = bus.t_far;
            nan_d = nan_q | nan_in;
          end
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DECIDE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DECIDE: begin
        hit_d   = ~nan_q & ~exit_lt_enter & ~exit_neg;
        state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      nan_q   <= 1'b0;
      hit_q   <= 1'b0;
      enter_q <= '0;
      exit_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nan_q   <= nan_d;
      hit_q   <= hit_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == OUT);
  assign bus.hit       = hit_q;
  assign bus.t_enter   = enter_q;
  assign bus.t_exit    = exit_q;

endmodule
